// File: rtl/side_info_sequencer.sv
// MPEG-1 Layer III frame sequencer: hunts sync, decodes the header, and splits the frame into side-info and main-data streams.
// Optional CRC-16 check of header bytes 2-3 plus side info is compiled in with `define CRC_CHECK_EN.
module side_info_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  axiid,
    input  logic        axiiv,
    output logic [7:0]  si_axiod,
    output logic        si_axiov,
    output logic        si_mono,
    output logic [7:0]  md_axiod,
    output logic        md_axiov,
    output logic        md_last,
    output logic        hdr_valid,
    output logic [3:0]  bitrate_idx,
    output logic [1:0]  samp_idx,
    output logic        padding,
    output logic [1:0]  mode,
    output logic [1:0]  mode_ext,
    output logic [10:0] frame_bytes,
    output logic        sync_lost,
    output logic        crc_err
);

    typedef enum logic [2:0] {HUNT, HDR, CRC, SIDE, MAIN} state_t;

    // floor(144000 * kbps / fs) per bitrate index, one table per sample rate
    localparam logic [10:0] FB_44K [16] = '{11'd0, 11'd104, 11'd130, 11'd156, 11'd182, 11'd208, 11'd261, 11'd313,
                                            11'd365, 11'd417, 11'd522, 11'd626, 11'd731, 11'd835, 11'd1044, 11'd0};
    localparam logic [10:0] FB_48K [16] = '{11'd0, 11'd96, 11'd120, 11'd144, 11'd168, 11'd192, 11'd240, 11'd288,
                                            11'd336, 11'd384, 11'd480, 11'd576, 11'd672, 11'd768, 11'd960, 11'd0};
    localparam logic [10:0] FB_32K [16] = '{11'd0, 11'd144, 11'd180, 11'd216, 11'd252, 11'd288, 11'd360, 11'd432,
                                            11'd504, 11'd576, 11'd720, 11'd864, 11'd1008, 11'd1152, 11'd1440, 11'd0};

    state_t      state, state_nxt;
    logic [10:0] cnt, cnt_nxt, cnt_dec;
    logic        last;
    logic [6:0]  hdr_b2;
    logic        prot;
    logic        seen_ff, seen_ff_nxt;
    logic        sync2_ok, b2_bad, hdr_miss, hdr_bad;
    logic [10:0] fb_base, si_len_new, si_len_cur, main_len;
    logic        si_fwd, md_fwd, md_end, miss, hdr_take, b2_take, sync_take;

    assign cnt_dec    = (cnt == '0) ? '0 : cnt - 11'd1;
    assign last       = (cnt == 11'd1);
    assign sync2_ok   = (axiid[7:1] == 7'b1111101);
    assign b2_bad     = (axiid[7:4] == 4'h0) || (axiid[7:4] == 4'hF) || (axiid[3:2] == 2'b11);
    // HDR counts down 4..1 from a frame boundary, 2..1 after a hunt
    assign hdr_miss   = (state == HDR) && (((cnt == 11'd4) && (axiid != 8'hFF)) ||
                                           ((cnt == 11'd3) && !sync2_ok));
    assign hdr_bad    = (state == HDR) && (cnt == 11'd2) && b2_bad;
    assign si_len_new = (axiid[7:6] == 2'b11) ? 11'd17 : 11'd32;
    assign si_len_cur = (mode == 2'b11) ? 11'd17 : 11'd32;
    assign main_len   = frame_bytes - 11'd4 - (prot ? 11'd0 : 11'd2) - si_len_cur;
    assign si_mono    = (mode == 2'b11);

    always_comb begin
        fb_base = '0;
        unique case (hdr_b2[2:1])
            2'd0:    fb_base = FB_44K[hdr_b2[6:3]];
            2'd1:    fb_base = FB_48K[hdr_b2[6:3]];
            2'd2:    fb_base = FB_32K[hdr_b2[6:3]];
            default: fb_base = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= HUNT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (axiiv) begin
            unique case (state)
                HUNT: if (seen_ff && sync2_ok) begin
                    state_nxt = HDR;
                    cnt_nxt   = 11'd2;
                end
                HDR: begin
                    cnt_nxt = cnt_dec;
                    if (hdr_miss || hdr_bad) begin
                        state_nxt = HUNT;
                        cnt_nxt   = '0;
                    end else if (last) begin
                        state_nxt = prot ? SIDE : CRC;
                        cnt_nxt   = prot ? si_len_new : 11'd2;
                    end
                end
                CRC: begin
                    state_nxt = last ? SIDE : CRC;
                    cnt_nxt   = last ? si_len_cur : cnt_dec;
                end
                SIDE: begin
                    state_nxt = last ? MAIN : SIDE;
                    cnt_nxt   = last ? main_len : cnt_dec;
                end
                MAIN: begin
                    state_nxt = last ? HDR : MAIN;
                    cnt_nxt   = last ? 11'd4 : cnt_dec;
                end
                default: begin
                    state_nxt = HUNT;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_comb begin
        si_fwd      = axiiv && (state == SIDE);
        md_fwd      = axiiv && (state == MAIN);
        md_end      = md_fwd && last;
        miss        = axiiv && hdr_miss;
        b2_take     = axiiv && (state == HDR) && (cnt == 11'd2);
        hdr_take    = axiiv && (state == HDR) && last;
        sync_take   = axiiv && sync2_ok && (((state == HUNT) && seen_ff) ||
                                            ((state == HDR) && (cnt == 11'd3)));
        // a byte that knocks us back to HUNT may itself be the next 0xFF
        seen_ff_nxt = seen_ff;
        if (axiiv)
            seen_ff_nxt = (state_nxt == HUNT) && (axiid == 8'hFF);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            si_axiod    <= '0;
            si_axiov    <= 1'b0;
            md_axiod    <= '0;
            md_axiov    <= 1'b0;
            md_last     <= 1'b0;
            hdr_valid   <= 1'b0;
            sync_lost   <= 1'b0;
            bitrate_idx <= '0;
            samp_idx    <= '0;
            padding     <= 1'b0;
            mode        <= '0;
            mode_ext    <= '0;
            frame_bytes <= '0;
            hdr_b2      <= '0;
            prot        <= 1'b0;
            seen_ff     <= 1'b0;
        end else begin
            si_axiov  <= si_fwd;
            md_axiov  <= md_fwd;
            md_last   <= md_end;
            hdr_valid <= hdr_take;
            sync_lost <= miss;
            seen_ff   <= seen_ff_nxt;
            if (si_fwd)    si_axiod <= axiid;
            if (md_fwd)    md_axiod <= axiid;
            if (sync_take) prot     <= axiid[0];
            if (b2_take)   hdr_b2   <= axiid[7:1];
            if (hdr_take) begin
                bitrate_idx <= hdr_b2[6:3];
                samp_idx    <= hdr_b2[2:1];
                padding     <= hdr_b2[0];
                mode        <= axiid[7:6];
                mode_ext    <= axiid[5:4];
                frame_bytes <= fb_base + {10'd0, hdr_b2[0]};
            end
        end
    end

`ifdef CRC_CHECK_EN
    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int unsigned i = 0; i < 8; i++) begin
            if (r[15] ^ d[3'(7 - i)]) r = {r[14:0], 1'b0} ^ 16'h8005;
            else                      r = {r[14:0], 1'b0};
        end
        return r;
    endfunction

    logic [15:0] crc_acc, crc_rx, crc_next;

    assign crc_next = crc16_byte(b2_take ? 16'hFFFF : crc_acc, axiid);

    always_ff @(posedge clk) begin
        if (!rst) begin
            crc_acc <= '0;
            crc_rx  <= '0;
            crc_err <= 1'b0;
        end else begin
            crc_err <= 1'b0;
            if (b2_take || hdr_take || si_fwd)
                crc_acc <= crc_next;
            if (axiiv && (state == CRC))
                crc_rx <= {crc_rx[7:0], axiid};
            if (si_fwd && last && !prot && (crc_next != crc_rx))
                crc_err <= 1'b1;
        end
    end
`else
    assign crc_err = 1'b0;
`endif

endmodule

// File: tb/tb_side_info_sequencer.sv
// Scoreboard bench for side_info_sequencer: frames are built here, expected side/main bytes and header fields
// are queued as they are driven and compared as the DUT emits them.
module tb_side_info_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  axiid;
    logic        axiiv;
    logic [7:0]  si_axiod;
    logic        si_axiov;
    logic        si_mono;
    logic [7:0]  md_axiod;
    logic        md_axiov;
    logic        md_last;
    logic        hdr_valid;
    logic [3:0]  bitrate_idx;
    logic [1:0]  samp_idx;
    logic        padding;
    logic [1:0]  mode;
    logic [1:0]  mode_ext;
    logic [10:0] frame_bytes;
    logic        sync_lost;
    logic        crc_err;

    side_info_sequencer dut (
        .clk(clk), .rst(rst), .axiid(axiid), .axiiv(axiiv),
        .si_axiod(si_axiod), .si_axiov(si_axiov), .si_mono(si_mono),
        .md_axiod(md_axiod), .md_axiov(md_axiov), .md_last(md_last),
        .hdr_valid(hdr_valid), .bitrate_idx(bitrate_idx), .samp_idx(samp_idx),
        .padding(padding), .mode(mode), .mode_ext(mode_ext), .frame_bytes(frame_bytes),
        .sync_lost(sync_lost), .crc_err(crc_err)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [7:0]  si_q[$];
    logic [8:0]  md_q[$];
    logic [21:0] hdr_q[$];
    int          sync_seen = 0, crc_seen = 0, exp_sync = 0, exp_crc = 0;
    logic        exp_mono = 1'b0;
    bit          gap_en = 1'b0;
    logic        v_q;

    int KBPS [16] = '{0, 32, 40, 48, 56, 64, 80, 96, 112, 128, 160, 192, 224, 256, 320, 0};
    int FS   [4]  = '{44100, 48000, 32000, 1};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 7; i >= 0; i--)
            r = (r[15] ^ d[i]) ? ((r << 1) ^ 16'h8005) : (r << 1);
        return r;
    endfunction

    function automatic logic [63:0] all_outs();
        return {19'd0, si_axiod, si_axiov, si_mono, md_axiod, md_axiov, md_last, hdr_valid,
                bitrate_idx, samp_idx, padding, mode, mode_ext, frame_bytes, sync_lost, crc_err};
    endfunction

    always @(posedge clk) v_q <= axiiv;

    always @(negedge clk) begin
        if (si_axiov) begin
            check("si_q_avail", si_q.size() != 0, 1);
            if (si_q.size() != 0) check("si_byte", si_axiod, si_q.pop_front());
            check("si_mono", si_mono, exp_mono);
        end
        if (md_axiov) begin
            check("md_q_avail", md_q.size() != 0, 1);
            if (md_q.size() != 0) check("md_byte_last", {md_last, md_axiod}, md_q.pop_front());
        end
        if (md_last) check("md_last_needs_valid", md_axiov, 1);
        if (hdr_valid) begin
            check("hdr_q_avail", hdr_q.size() != 0, 1);
            if (hdr_q.size() != 0)
                check("hdr_fields", {bitrate_idx, samp_idx, padding, mode, mode_ext, frame_bytes}, hdr_q.pop_front());
        end
        if (v_q === 1'b0) check("idle_axiov", {si_axiov, md_axiov}, 2'b00);
        if (sync_lost) sync_seen++;
        if (crc_err) crc_seen++;
    end

    task automatic send_byte(input logic [7:0] b);
        if (gap_en) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
                axiiv = 1'b0;
            end
        end
        @(posedge clk); #1;
        axiid = b;
        axiiv = 1'b1;
    endtask

    task automatic idle(input int n);
        @(posedge clk); #1;
        axiiv = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst   = 1'b0;
        axiiv = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("reset_outputs", all_outs(), 64'd0);
        si_q.delete();
        md_q.delete();
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3,
                              input bit flip, input int abort_at);
        int         fb, silen, mdlen;
        logic [7:0] sb[32];
        logic [15:0] c;
        logic [7:0] d;
        fb    = (144000 * KBPS[b2[7:4]]) / FS[b2[3:2]] + int'(b2[1]);
        silen = (b3[7:6] == 2'b11) ? 17 : 32;
        mdlen = fb - 4 - (b1[0] ? 0 : 2) - silen;
        exp_mono = (b3[7:6] == 2'b11);
        hdr_q.push_back({b2[7:4], b2[3:2], b2[1], b3[7:6], b3[5:4], 11'(fb)});
        c = crc_step(16'hFFFF, b2);
        c = crc_step(c, b3);
        for (int i = 0; i < silen; i++) begin
            sb[i] = 8'($urandom);
            c = crc_step(c, sb[i]);
        end
        send_byte(8'hFF);
        send_byte(b1);
        send_byte(b2);
        send_byte(b3);
        if (!b1[0]) begin
            if (flip) c[0] = ~c[0];
            send_byte(c[15:8]);
            send_byte(c[7:0]);
`ifdef CRC_CHECK_EN
            if (flip) exp_crc++;
`endif
        end
        for (int i = 0; i < silen; i++) begin
            si_q.push_back(sb[i]);
            send_byte(sb[i]);
        end
        for (int i = 0; i < mdlen; i++) begin
            if (i == abort_at) begin
                do_reset();
                return;
            end
            d = 8'($urandom);
            md_q.push_back({i == mdlen - 1, d});
            send_byte(d);
        end
    endtask

    initial begin
        rst   = 1'b0;
        axiiv = 1'b0;
        axiid = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs_init", all_outs(), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        send_frame(8'hFB, 8'h90, 8'h40, 1'b0, -1);   // stereo, 417 bytes
        send_frame(8'hFB, 8'h90, 8'hC0, 1'b0, -1);   // mono
        send_frame(8'hFA, 8'h90, 8'h40, 1'b0, -1);   // CRC present, correct
        send_frame(8'hFA, 8'h90, 8'h40, 1'b1, -1);   // CRC present, corrupted
        send_byte(8'hFF); send_byte(8'hFB); send_byte(8'hF0); send_byte(8'h40);
        send_frame(8'hFB, 8'h5A, 8'h90, 1'b0, -1);   // 32 kHz, padded, found by hunting
        idle(3);
        check("sync_lost_none", sync_seen, exp_sync);
        check("crc_err_count_a", crc_seen, exp_crc);

        send_byte(8'h00); send_byte(8'hFB); send_byte(8'h90); send_byte(8'h40);
        exp_sync++;
        send_byte(8'hFF);
        send_frame(8'hFB, 8'h94, 8'h40, 1'b0, -1);   // FF FF FB resync
        idle(3);
        check("sync_lost_one", sync_seen, exp_sync);

        gap_en = 1'b1;
        send_frame(8'hFA, 8'hE4, 8'hF0, 1'b0, -1);   // 960-byte mono with CRC, idle gaps
        send_frame(8'hFB, 8'h90, 8'h40, 1'b0, 100);  // reset at main-data byte 100
        send_frame(8'hFB, 8'h10, 8'h00, 1'b0, -1);   // smallest frame, 104 bytes
        idle(5);

        check("si_q_drained", si_q.size(), 0);
        check("md_q_drained", md_q.size(), 0);
        check("hdr_q_drained", hdr_q.size(), 0);
        check("sync_lost_final", sync_seen, exp_sync);
        check("crc_err_final", crc_seen, exp_crc);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
